// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and line idle level.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DefaultOversample = 16;
  localparam int unsigned DefaultDataBits   = 8;
  localparam logic        IdleLevel         = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts baud ticks 0..OVERSAMPLE-1 and flags the tick that ends a bit.
// A synchronous clear holds the count at zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DefaultOversample
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = tick && !clear && (cnt_q == CntMax);
    cnt_d   = cnt_q;
    if (clear || bit_end) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, STOP_BITS stop bits.
// Parity is included when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefaultDataBits,
  parameter int unsigned OVERSAMPLE = DefaultOversample,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_uart,
  input  logic                 start_tx,
  input  logic [DATA_BITS-1:0] t_data,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 done_q, done_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Timer is held cleared while idle so every frame starts on a fresh bit boundary.
  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (baud_uart),
    .clear  (state_q == StIdle),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      StIdle: begin
        // done_q blocks a restart on the completion cycle, forcing one idle-high clk.
        if (start_tx && !done_q) begin
          state_d   = StStart;
          shift_d   = t_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^t_data;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == BitCntW'(STOP_BITS - 1)) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    txd = IdleLevel;
    case (state_q)
      StStart:  txd = 1'b0;
      StData:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd = parity_q;
`endif
      default:  txd = IdleLevel;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (default parameters); parity steps run when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_uart = 1'b1;
  logic       start_tx = 1'b0;
  logic [7:0] t_data = 8'h00;
  logic       txd, busy, done;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .baud_uart(baud_uart),
    .start_tx (start_tx),
    .t_data   (t_data),
    .txd      (txd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame vector index 0 is the start bit; bits above the frame are stop (high).
  function automatic logic [11:0] frame_of(input logic [7:0] d);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    t_data = d;
    start_tx = 1'b1;
    @(negedge clk);
    start_tx = 1'b0;
  endtask

  // Called on the first sample after the start edge; ends on the sample after done.
  task automatic watch(input string tag, input logic [11:0] fr, input int w, input bit throttle,
                       input int chg_at, input logic [7:0] chg_data);
    int busy_cnt, done_at, done_cnt, bad, lim;
    busy_cnt = 0; done_at = -1; done_cnt = 0; bad = 0;
    lim = NB * w + 50;
    for (int i = 0; i < lim; i++) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (i / w >= NB) bad++;
        else if (txd !== fr[i / w]) bad++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (done_at >= 0) break;
      if (i == chg_at) t_data = chg_data;
      if (throttle) baud_uart = i[0];
      @(negedge clk);
    end
    baud_uart = 1'b1;
    check({tag, " bad_levels"}, bad, 0);
    check({tag, " busy_clks"}, busy_cnt, NB * w);
    check({tag, " done_at"}, done_at, NB * w);
    check({tag, " done_count"}, done_cnt, 1);
    @(negedge clk);
    check({tag, " done_one_clk"}, done, 1'b0);
    check({tag, " gap_busy"}, busy, 1'b0);
    check({tag, " gap_txd"}, txd, 1'b1);
  endtask

  initial begin
    int bad, n;
    logic t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset txd", txd, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);

    // Idle with ticks running.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_1000", bad, 0);

    // Frame A5: 0,1,0,1,0,0,1,0,1,(parity 0),1
    send(8'hA5);
    check("a5 first busy", busy, 1'b1);
    check("a5 first txd", txd, 1'b0);
`ifdef UART_TX_PARITY_EN
    watch("a5", 12'b1_1_0_10100101_0, 16, 1'b0, -1, 8'h00);
`else
    watch("a5", {2'b11, 10'b1101001010}, 16, 1'b0, -1, 8'h00);
`endif

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    watch("par07", 12'b1_1_1_00000111_0, 16, 1'b0, -1, 8'h00);
    send(8'h03);
    watch("par03", 12'b1_1_0_00000011_0, 16, 1'b0, -1, 8'h00);
`endif

    // Back-to-back with start_tx held high and t_data changed mid-frame.
    t_data = 8'h3C;
    start_tx = 1'b1;
    @(negedge clk);
    watch("b2b1", frame_of(8'h3C), 16, 1'b0, 50, 8'hC3);
    @(negedge clk);
    watch("b2b2", frame_of(8'hC3), 16, 1'b0, -1, 8'h00);
    start_tx = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b stopped", busy, 1'b0);

    // Reset mid-frame.
    send(8'h96);
    repeat (50) @(negedge clk);
    check("rst pre busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst txd", txd, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || txd !== 1'b1) bad++;
    end
    check("rst no_done", bad, 0);
    send(8'h96);
    watch("after_rst", frame_of(8'h96), 16, 1'b0, -1, 8'h00);

    // Half-rate ticks: every bit 32 clks.
    send(8'h4B);
    watch("throttle", frame_of(8'h4B), 32, 1'b1, -1, 8'h00);

    // Freeze with baud_uart low mid-bit, then resume.
    send(8'h5A);
    repeat (20) @(negedge clk);
    baud_uart = 1'b0;
    t0 = txd;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== t0 || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check("freeze hold", bad, 0);
    baud_uart = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("freeze resume_clks", n, NB * 16 - 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
